// File: rtl/viterbi_pkg.sv
// Shared constants, puncture tables and helpers for the punctured K=7 Viterbi decoder.
package viterbi_pkg;

  localparam int unsigned K      = 7;
  localparam int unsigned SW     = K - 1;
  localparam int unsigned NSTATE = 1 << SW;

  localparam logic [K-1:0] G0_DEF = 7'o133;
  localparam logic [K-1:0] G1_DEF = 7'o171;

  localparam logic [1:0] RATE_1_2 = 2'd0;
  localparam logic [1:0] RATE_2_3 = 2'd1;
  localparam logic [1:0] RATE_3_4 = 2'd2;

  // Starting metric for every state other than 0, so the all-zero start state wins early.
  localparam int unsigned PM_INIT = 32;

  // What the current coded bit does inside its puncture pattern.
  typedef enum logic [1:0] {
    PK_HOLD_A  = 2'd0,  // A bit, wait for its B partner
    PK_EMIT_AB = 2'd1,  // B bit, completes (held A, B)
    PK_EMIT_AE = 2'd2,  // A bit whose B was punctured
    PK_EMIT_EB = 2'd3   // B bit whose A was punctured
  } punct_kind_e;

  // Depunctured bit pair with erasure flags.
  typedef struct packed {
    logic a;
    logic b;
    logic ea;
    logic eb;
    logic last;
  } pair_t;

  // Puncture pattern table indexed by rate and phase.
  function automatic punct_kind_e punct_kind(input logic [1:0] rate, input logic [1:0] phase);
    punct_kind_e k;
    k = PK_HOLD_A;
    case (rate)
      RATE_2_3: begin
        case (phase)
          2'd0:    k = PK_HOLD_A;
          2'd1:    k = PK_EMIT_AB;
          default: k = PK_EMIT_AE;
        endcase
      end
      RATE_3_4: begin
        case (phase)
          2'd0:    k = PK_HOLD_A;
          2'd1:    k = PK_EMIT_AB;
          2'd2:    k = PK_EMIT_AE;
          default: k = PK_EMIT_EB;
        endcase
      end
      default: k = (phase == 2'd0) ? PK_HOLD_A : PK_EMIT_AB;
    endcase
    return k;
  endfunction

  // Phase index of the final coded bit in each rate's pattern.
  function automatic logic [1:0] punct_phase_end(input logic [1:0] rate);
    logic [1:0] p;
    case (rate)
      RATE_2_3: p = 2'd2;
      RATE_3_4: p = 2'd3;
      default:  p = 2'd1;
    endcase
    return p;
  endfunction

  // Hamming branch metric; erased bits contribute nothing.
  function automatic logic [1:0] branch_metric(input pair_t p, input logic exp_a, input logic exp_b);
    logic [1:0] m;
    m = 2'd0;
    if (!p.ea && (p.a != exp_a)) m = m + 2'd1;
    if (!p.eb && (p.b != exp_b)) m = m + 2'd1;
    return m;
  endfunction

endpackage

// File: rtl/viterbi_depuncture.sv
// Serial coded bits -> registered (A,B) pairs with erasure flags, per-frame rate.
module viterbi_depuncture
  import viterbi_pkg::*;
(
  input  logic       Clk,
  input  logic       reset,
  input  logic       i_valid,
  input  logic       i_bit,
  input  logic       i_last,
  input  logic [1:0] i_rate,
  output logic       o_valid,
  output pair_t      o_pair
);

  logic        r_active;
  logic [1:0]  r_rate;
  logic [1:0]  r_phase;
  logic        r_held_a;

  logic [1:0]  w_rate;
  punct_kind_e w_kind;
  logic        w_emit;
  pair_t       w_pair;

  // Rate is frozen after the first bit of a frame; reserved code folds to 1/2.
  always_comb begin
    w_rate = r_active ? r_rate : ((i_rate == 2'd3) ? RATE_1_2 : i_rate);
    w_kind = punct_kind(w_rate, r_phase);
    w_emit = 1'b0;
    w_pair = '0;
    case (w_kind)
      PK_HOLD_A: begin
        w_emit    = i_last;
        w_pair.a  = i_bit;
        w_pair.eb = 1'b1;
      end
      PK_EMIT_AB: begin
        w_emit   = 1'b1;
        w_pair.a = r_held_a;
        w_pair.b = i_bit;
      end
      PK_EMIT_AE: begin
        w_emit    = 1'b1;
        w_pair.a  = i_bit;
        w_pair.eb = 1'b1;
      end
      default: begin
        w_emit    = 1'b1;
        w_pair.b  = i_bit;
        w_pair.ea = 1'b1;
      end
    endcase
    w_pair.last = i_last;
  end

  // Phase counter, held A bit and registered pair output.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_active <= 1'b0;
      r_rate   <= RATE_1_2;
      r_phase  <= 2'd0;
      r_held_a <= 1'b0;
      o_valid  <= 1'b0;
      o_pair   <= '0;
    end else begin
      o_valid <= i_valid & w_emit;
      if (i_valid) begin
        if (w_emit) o_pair <= w_pair;
        if (w_kind == PK_HOLD_A) r_held_a <= i_bit;
        if (i_last) begin
          r_active <= 1'b0;
          r_phase  <= 2'd0;
        end else begin
          r_active <= 1'b1;
          r_rate   <= w_rate;
          r_phase  <= (r_phase == punct_phase_end(w_rate)) ? 2'd0 : 2'(r_phase + 2'd1);
        end
      end
    end
  end

endmodule

// File: rtl/viterbi_decoder_punct.sv
// Streaming K=7 hard-decision Viterbi decoder with depuncturing and register-exchange survivors.
module viterbi_decoder_punct
  import viterbi_pkg::*;
#(
  parameter int unsigned  TB_DEPTH = 36,
  parameter int unsigned  PM_W     = 8,
  parameter logic [K-1:0] G0       = G0_DEF,
  parameter logic [K-1:0] G1       = G1_DEF
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [1:0] rate,
  input  logic       in_valid,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       in_ready,
  output logic       out_valid,
  output logic       out_bit,
  output logic       out_last,
  output logic       busy
);

  localparam int unsigned D     = TB_DEPTH;
  localparam int unsigned CNT_W = $clog2(D + 1);
  localparam int unsigned IDX_W = $clog2(D);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [PM_W-1:0]  r_pm   [NSTATE];
  logic [D-1:0]     r_surv [NSTATE];
  logic [PM_W-1:0]  w_pm_nxt   [NSTATE];
  logic [D-1:0]     w_surv_nxt [NSTATE];
  logic [CNT_W-1:0] r_steps;
  logic [IDX_W-1:0] r_flush_idx;
  logic             r_flush_end;
  logic             r_in_ready;
  logic             r_busy;
  logic             r_out_valid;
  logic             r_out_bit;
  logic             r_out_last;

  logic             w_accept;
  logic             w_pair_valid;
  pair_t            w_pair;
  logic             w_step;
  logic [SW-1:0]    w_best;

  assign w_accept = in_valid & r_in_ready;
  assign w_step   = w_pair_valid && (r_state == ST_RUN);

  viterbi_depuncture u_depuncture (
    .Clk     (Clk),
    .reset   (reset),
    .i_valid (w_accept),
    .i_bit   (in_bit),
    .i_last  (in_last),
    .i_rate  (rate),
    .o_valid (w_pair_valid),
    .o_pair  (w_pair)
  );

  // Add-compare-select and survivor exchange, one lane per next state.
  for (genvar g = 0; g < NSTATE; g++) begin : g_acs
    localparam logic [SW-1:0] NS = SW'(g);
    localparam logic [SW-1:0] P0 = {NS[SW-2:0], 1'b0};
    localparam logic [SW-1:0] P1 = {NS[SW-2:0], 1'b1};
    localparam logic [K-1:0]  T0 = {NS[SW-1], P0};
    localparam logic [K-1:0]  T1 = {NS[SW-1], P1};

    logic [1:0]      w_bm0;
    logic [1:0]      w_bm1;
    logic [PM_W-1:0] w_c0;
    logic [PM_W-1:0] w_c1;
    logic [PM_W-1:0] w_diff;
    logic            w_sel1;

    assign w_bm0  = branch_metric(w_pair, ^(G0 & T0), ^(G1 & T0));
    assign w_bm1  = branch_metric(w_pair, ^(G0 & T1), ^(G1 & T1));
    assign w_c0   = r_pm[P0] + PM_W'(w_bm0);
    assign w_c1   = r_pm[P1] + PM_W'(w_bm1);
    assign w_diff = w_c0 - w_c1;
    // Take the odd predecessor only when strictly better (modulo compare).
    assign w_sel1 = !w_diff[PM_W-1] && (w_diff != '0);
    assign w_pm_nxt[g]   = w_sel1 ? w_c1 : w_c0;
    assign w_surv_nxt[g] = {(w_sel1 ? r_surv[P1][D-2:0] : r_surv[P0][D-2:0]), NS[SW-1]};
  end

  // Pairwise min-PM tree over current metrics; ties keep the lower index.
  always_comb begin : min_pm
    logic [PM_W-1:0] v_pm  [NSTATE];
    logic [SW-1:0]   v_idx [NSTATE];
    logic [PM_W-1:0] v_d;
    v_d = '0;
    for (int i = 0; i < NSTATE; i++) begin
      v_pm[i]  = r_pm[i];
      v_idx[i] = SW'(i);
    end
    for (int w = NSTATE / 2; w >= 1; w = w / 2) begin
      for (int i = 0; i < w; i++) begin
        v_d = v_pm[2*i+1] - v_pm[2*i];
        if (v_d[PM_W-1]) begin
          v_pm[i]  = v_pm[2*i+1];
          v_idx[i] = v_idx[2*i+1];
        end else begin
          v_pm[i]  = v_pm[2*i];
          v_idx[i] = v_idx[2*i];
        end
      end
    end
    w_best = v_idx[0];
  end

  // Frame FSM next state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_step && w_pair.last) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (r_flush_end) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Frame FSM state register.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Metrics, survivors, step/flush counters and registered outputs.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NSTATE; i++) begin
        r_pm[i]   <= (i == 0) ? '0 : PM_W'(PM_INIT);
        r_surv[i] <= '0;
      end
      r_steps     <= '0;
      r_flush_idx <= '0;
      r_flush_end <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_bit   <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_out_bit   <= 1'b0;
      r_out_last  <= 1'b0;
      if (w_accept) begin
        r_busy <= 1'b1;
        if (in_last) r_in_ready <= 1'b0;
      end
      if (w_step) begin
        for (int i = 0; i < NSTATE; i++) begin
          r_pm[i]   <= w_pm_nxt[i];
          r_surv[i] <= w_surv_nxt[i];
        end
        if (r_steps >= CNT_W'(D)) begin
          r_out_valid <= 1'b1;
          r_out_bit   <= r_surv[w_best][D-1];
        end else begin
          r_steps <= CNT_W'(r_steps + 1'b1);
        end
        if (w_pair.last) begin
          r_flush_idx <= (r_steps >= CNT_W'(D)) ? IDX_W'(D - 1) : IDX_W'(r_steps);
          r_flush_end <= 1'b0;
        end
      end
      if (r_state == ST_FLUSH) begin
        if (!r_flush_end) begin
          r_out_valid <= 1'b1;
          r_out_bit   <= r_surv[0][r_flush_idx];
          r_out_last  <= (r_flush_idx == '0);
          if (r_flush_idx == '0) r_flush_end <= 1'b1;
          else                   r_flush_idx <= IDX_W'(r_flush_idx - 1'b1);
        end else begin
          for (int i = 0; i < NSTATE; i++) begin
            r_pm[i]   <= (i == 0) ? '0 : PM_W'(PM_INIT);
            r_surv[i] <= '0;
          end
          r_steps     <= '0;
          r_flush_end <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_bit   = r_out_bit;
  assign out_last  = r_out_last;
  assign busy      = r_busy;

endmodule
